// File: rtl/mult_div_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_pkg
//   Shared definitions for the multi-cycle multiply/divide unit: FSM state
//   encoding, default operand width and the start-to-done latency that the
//   control unit's wait counter also relies on.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mult_div_pkg;

  localparam int MD_WIDTH   = 32;
  localparam int MD_LATENCY = MD_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

endpackage

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative signed multiply (radix-2 Booth) and signed divide (restoring,
//   on magnitudes, truncating toward zero). One shared accumulator/counter.
//   Ports:
//     clk, reset (async, active-low)
//     mult_start / div_start : one-cycle start strobes (multiply has priority)
//     a, b                   : operands, sampled in the start cycle only
//     busy                   : FSM not idle
//     done                   : one-cycle pulse, hi/lo valid from here on
//     div_zero               : with done when the divisor was zero
//     hi, lo                 : product high/low, or remainder/quotient
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);

  md_state_t          r_state;
  md_state_t          w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH:0]   r_acc;      // mult: {A, Q, q-1}; div: {0, R, Q}
  logic [WIDTH-1:0]   r_opd;      // multiplicand, or divisor magnitude
  logic               r_neg_q;
  logic               r_neg_r;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dz;

  logic               w_last;
  logic               w_b_zero;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_a_ext;
  logic [WIDTH:0]     w_m_ext;
  logic [WIDTH:0]     w_bsum;
  logic [2*WIDTH:0]   w_booth_acc;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_fit;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH:0]   w_div_acc;
  logic [WIDTH-1:0]   w_quot_s;
  logic [WIDTH-1:0]   w_rem_s;

  assign w_last   = (r_cnt == CNT_LAST);
  assign w_b_zero = (b == '0);
  assign w_abs_a  = a[WIDTH-1] ? -a : a;
  assign w_abs_b  = b[WIDTH-1] ? -b : b;

  // Booth step. A is widened by one bit so that subtracting the most
  // negative multiplicand cannot overflow; the widened sum concatenated with
  // Q is exactly the arithmetically shifted accumulator.
  assign w_a_ext = {r_acc[2*WIDTH], r_acc[2*WIDTH:WIDTH+1]};
  assign w_m_ext = {r_opd[WIDTH-1], r_opd};

  always_comb begin
    w_bsum = w_a_ext;
    case (r_acc[1:0])
      2'b01:   w_bsum = w_a_ext + w_m_ext;
      2'b10:   w_bsum = w_a_ext - w_m_ext;
      default: w_bsum = w_a_ext;
    endcase
  end

  assign w_booth_acc = {w_bsum, r_acc[WIDTH:1]};

  // Restoring divide step on {R, Q}: shift left, trial-subtract the divisor,
  // keep the difference when it does not borrow.
  assign w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_opd};
  assign w_fit     = ~w_diff[WIDTH];
  assign w_rem     = w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_div_acc = {1'b0, w_rem, r_acc[WIDTH-2:0], w_fit};

  assign w_quot_s = r_neg_q ? -w_div_acc[WIDTH-1:0] : w_div_acc[WIDTH-1:0];
  assign w_rem_s  = r_neg_r ? -w_div_acc[2*WIDTH-1:WIDTH]
                            : w_div_acc[2*WIDTH-1:WIDTH];

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (mult_start)     w_next = MULT;
        else if (div_start) w_next = w_b_zero ? DONE : DIV;
      end
      MULT:    if (w_last) w_next = DONE;
      DIV:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opd   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE);
      r_dz   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (mult_start) begin
            r_opd <= a;
            r_acc <= {{WIDTH{1'b0}}, b, 1'b0};
            r_cnt <= '0;
          end else if (div_start) begin
            if (w_b_zero) begin
              r_dz <= 1'b1;
            end else begin
              r_opd   <= w_abs_b;
              r_acc   <= {1'b0, {WIDTH{1'b0}}, w_abs_a};
              r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
              r_neg_r <= a[WIDTH-1];
              r_cnt   <= '0;
            end
          end
        end
        MULT: begin
          r_acc <= w_booth_acc;
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_hi <= w_booth_acc[2*WIDTH:WIDTH+1];
            r_lo <= w_booth_acc[WIDTH:1];
          end
        end
        DIV: begin
          r_acc <= w_div_acc;
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_hi <= w_rem_s;
            r_lo <= w_quot_s;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_dz;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

`default_nettype wire
